// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each access runs IDLE -> ISSUE (-> WAIT for reads) -> IDLE. Every output is driven from a register.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state_reg;
  logic                last_reg;   // 1 = port 1 was granted most recently
  logic                sel_reg;    // port that owns the access in flight
  logic                gnt0_reg, gnt1_reg, rvalid0_reg, rvalid1_reg;
  logic                mem_we_reg, busy_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg, rdata0_reg, rdata1_reg;
  logic                pick1_next;

  // Port 1 wins when it asks alone, or when both ask and port 0 went last.
  always_comb begin
    pick1_next = req1 && (!req0 || !last_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      sel_reg       <= 1'b0;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      rvalid0_reg   <= 1'b0;
      rvalid1_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata0_reg    <= '0;
      rdata1_reg    <= '0;
    end else begin
      gnt0_reg    <= 1'b0;
      gnt1_reg    <= 1'b0;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            sel_reg       <= pick1_next;
            last_reg      <= pick1_next;
            gnt0_reg      <= !pick1_next;
            gnt1_reg      <= pick1_next;
            mem_addr_reg  <= pick1_next ? addr1 : addr0;
            mem_we_reg    <= pick1_next ? we1 : we0;
            mem_wdata_reg <= pick1_next ? wdata1 : wdata0;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          // The RAM samples mem_* at this edge; a write is done, a read still needs q.
          mem_we_reg <= 1'b0;
          if (mem_we_reg) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (sel_reg) begin
            rdata1_reg  <= mem_rdata;
            rvalid1_reg <= 1'b1;
          end else begin
            rdata0_reg  <= mem_rdata;
            rvalid0_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          mem_we_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign rvalid0   = rvalid0_reg;
  assign rvalid1   = rvalid1_reg;
  assign rdata0    = rdata0_reg;
  assign rdata1    = rdata1_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM behind it.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  // Single-port RAM, read-before-write, q one cycle after the address is sampled.
  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt0"}, gnt0, 0);
    check({tag, "_gnt1"}, gnt1, 0);
    check({tag, "_rvalid0"}, rvalid0, 0);
    check({tag, "_rvalid1"}, rvalid1, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    $display("reset: outputs checked");
    reset = 1'b0;

    // Port 0 writes 0x3FF to 0x000F
    req0 = 1; we0 = 1; addr0 = 16'h000F; wdata0 = 32'h0000_03FF;
    @(negedge clk);
    check("wr_gnt0", gnt0, 1);
    check("wr_gnt1", gnt1, 0);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16'h000F);
    check("wr_mem_wdata", mem_wdata, 32'h0000_03FF);
    check("wr_busy_c1", busy, 1);
    req0 = 0; we0 = 0;
    @(negedge clk);
    check("wr_mem_we_c2", mem_we, 0);
    check("wr_busy_c2", busy, 0);
    check("wr_gnt0_c2", gnt0, 0);
    $display("port0 write 0x000F <= 0x3FF done");

    // Port 1 reads 0x000F back
    req1 = 1; we1 = 0; addr1 = 16'h000F;
    @(negedge clk);
    check("rd_gnt1", gnt1, 1);
    check("rd_gnt0", gnt0, 0);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 16'h000F);
    req1 = 0;
    @(negedge clk);
    check("rd_rvalid1_c2", rvalid1, 0);
    check("rd_busy_c2", busy, 1);
    @(negedge clk);
    check("rd_rvalid1_c3", rvalid1, 1);
    check("rd_rvalid0_c3", rvalid0, 0);
    check("rd_rdata1", rdata1, 32'h0000_03FF);
    check("rd_rdata0", rdata0, 0);
    check("rd_busy_c3", busy, 0);
    @(negedge clk);
    check("rd_rvalid1_c4", rvalid1, 0);
    check("rd_rdata1_hold", rdata1, 32'h0000_03FF);
    $display("port1 read 0x000F -> %0h", rdata1);

    // Both ports write continuously right after reset: 0,1,0,1 every 2 cycles
    reset = 1;
    @(negedge clk);
    reset = 0;
    req0 = 1; we0 = 1; addr0 = 16'h0001; wdata0 = 32'hA1A1_A1A1;
    req1 = 1; we1 = 1; addr1 = 16'h0002; wdata1 = 32'hB2B2_B2B2;
    for (int c = 1; c <= 8; c++) begin
      logic e0, e1;
      @(negedge clk);
      e0 = (c == 1) || (c == 5);
      e1 = (c == 3) || (c == 7);
      check($sformatf("rr_gnt0_c%0d", c), gnt0, e0);
      check($sformatf("rr_gnt1_c%0d", c), gnt1, e1);
      if (e0 || e1) begin
        check($sformatf("rr_addr_c%0d", c), mem_addr, e0 ? 16'h0001 : 16'h0002);
        check($sformatf("rr_we_c%0d", c), mem_we, 1);
      end
      $display("rr cycle %0d: gnt0=%0b gnt1=%0b", c, gnt0, gnt1);
      if (c == 8) begin
        req0 = 0; req1 = 0;
      end
    end

    // Only port 1, three back-to-back reads of 0x0002
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 16'h0002;
    for (int c = 1; c <= 9; c++) begin
      logic eg, ev;
      @(negedge clk);
      eg = (c == 1) || (c == 4) || (c == 7);
      ev = (c == 3) || (c == 6) || (c == 9);
      check($sformatf("p1_gnt0_c%0d", c), gnt0, 0);
      check($sformatf("p1_gnt1_c%0d", c), gnt1, eg);
      check($sformatf("p1_rvalid1_c%0d", c), rvalid1, ev);
      check($sformatf("p1_mem_we_c%0d", c), mem_we, 0);
      if (ev) check($sformatf("p1_rdata1_c%0d", c), rdata1, 32'hB2B2_B2B2);
      $display("p1 cycle %0d: gnt1=%0b rvalid1=%0b rdata1=%0h", c, gnt1, rvalid1, rdata1);
      if (c == 7) req1 = 0;
    end

    // Reset during WAIT of a port 0 read aborts it
    req0 = 1; we0 = 0; addr0 = 16'h000F;
    @(negedge clk);
    check("ab_gnt0", gnt0, 1);
    req0 = 0;
    @(negedge clk);
    check("ab_busy_wait", busy, 1);
    check("ab_rvalid0_wait", rvalid0, 0);
    reset = 1;
    @(negedge clk);
    check_idle_outputs("abort");
    reset = 0;
    req0 = 1; we0 = 1; addr0 = 16'h0005; wdata0 = 32'h5555_5555;
    req1 = 1; we1 = 1; addr1 = 16'h0006; wdata1 = 32'h6666_6666;
    @(negedge clk);
    check("ab_tie_gnt0", gnt0, 1);
    check("ab_tie_gnt1", gnt1, 0);
    check("ab_tie_addr", mem_addr, 16'h0005);
    check("ab_rvalid0_after", rvalid0, 0);
    $display("abort: tie after reset granted port %0d", gnt1 ? 1 : 0);
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  access request from port 0 (processor core) / port 1 (auxiliary master).
REQ-006 we0 / we1  input  1  1 = write, 0 = read, per port.
REQ-007 addr0 / addr1  input  ADDR_W  word address, per port.
REQ-008 wdata0 / wdata1  input  DATA_W  write data, per port.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: request accepted.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid on rdataN.
REQ-011 rdata0 / rdata1  output  DATA_W  read-return data, registered, per port.
REQ-012 mem_addr  output  ADDR_W  address to single-port synchronous RAM.
REQ-013 mem_wdata  output  DATA_W  write data to RAM.
REQ-014 mem_we  output  1  RAM write enable.
REQ-015 mem_rdata  input  DATA_W  RAM q; valid one cycle after the RAM samples a read address.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and WAIT; all outputs SHALL be registered.
REQ-018 In IDLE with no request, SHALL remain in IDLE with mem_we=0.
REQ-019 In IDLE with exactly one reqN=1, SHALL grant port N; with both high, SHALL grant the port not granted most recently.
REQ-020 On a grant at edge E, SHALL set mem_addr/mem_we/mem_wdata from the winner's addrN/weN/wdataN, pulse gntN high for the cycle after E, and enter ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle; mem_* SHALL stay stable throughout so the RAM samples them at the ISSUE closing edge.
REQ-022 At the ISSUE closing edge, SHALL clear mem_we, then go to IDLE for a write or to WAIT for a read.
REQ-023 WAIT SHALL last one cycle; at its closing edge SHALL load mem_rdata into rdataN of the granted port, pulse rvalidN for one cycle and return to IDLE.
REQ-024 rdataN SHALL hold its value until the next read completes on that port; the other port's rdata SHALL be unaffected.
REQ-025 Latency from req sampled in IDLE (cycle 0): gnt in cycle 1, write committed at end of cycle 1, rvalid in cycle 3.
REQ-026 Minimum spacing: a write occupies 2 cycles and a read 3 cycles per access; arbitration during the rvalid cycle is permitted.
REQ-027 Requesters SHALL hold req/we/addr/wdata stable until gnt and SHALL drop or renew req in the cycle after gnt; the arbiter SHALL ignore req outside IDLE.
REQ-028 The round-robin pointer SHALL update only on a grant; a sole requester SHALL always win regardless of the pointer.
REQ-029 gnt0 and gnt1 SHALL never both be high; rvalid0 and rvalid1 SHALL never both be high.
REQ-030 No address decode or width conversion SHALL take place; addresses pass unchanged.

Reset
REQ-031 When reset is high at an edge, SHALL enter IDLE, clear mem_we, gnt0/1, rvalid0/1 and busy, and set the pointer so port 0 wins the next tie.
REQ-032 Reset SHALL clear rdata0/1, mem_addr and mem_wdata to 0.
REQ-033 Reset during ISSUE or WAIT SHALL abort the access: no rvalid, and mem_we=0 from the following cycle.
REQ-034 Reset has priority over all other events in the same cycle.

Verification
REQ-035 Port 0 writes 0x000003FF to addr 0x000F -> gnt0 in cycle 1, mem_we=1 with addr 0x000F only in cycle 1, busy low in cycle 2.
REQ-036 Port 1 reads addr 0x000F after REQ-035 -> gnt1 in cycle 1, rvalid1 in cycle 3, rdata1=0x000003FF, rdata0 unchanged.
REQ-037 Both ports request continuously with writes, starting right after reset -> grants alternate 0,1,0,1, each spaced 2 cycles apart.
REQ-038 Only port 1 requests, three back-to-back reads -> three gnt1 pulses, no gnt0, three rvalid1 pulses spaced 3 cycles apart.
REQ-039 Assert reset during WAIT of a port 0 read -> no rvalid0, all outputs 0 next cycle, and the next simultaneous request grants port 0.
